// File: rtl/wb_stage.sv
// Writeback stage: one pipeline register from memory stage, result select, retire counter.
// Optional load extraction is built when WB_LOAD_EXT_EN is defined.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_m,
    input  logic              regwrite_m,
    input  logic [ADDR_W-1:0] rd_m,
    input  logic [1:0]        resultsrc_m,
    input  logic [DATA_W-1:0] aluresult_m,
    input  logic [DATA_W-1:0] readdata_m,
    input  logic [DATA_W-1:0] pcplus4_m,
    input  logic [2:0]        funct3_m,
    input  logic              stall_w,
    input  logic              flush_w,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              valid_w,
    output logic              regwrite_w,
    output logic [ADDR_W-1:0] rd_w,
    output logic [31:0]       instret
);

    logic [1:0]        resultsrc_q;
    logic [DATA_W-1:0] aluresult_q;
    logic [DATA_W-1:0] readdata_q;
    logic [DATA_W-1:0] pcplus4_q;
    logic [DATA_W-1:0] load_data;

    // Flush only needs to kill the control bits; data fields are don't-care then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_w    <= 1'b0;
            regwrite_w <= 1'b0;
        end else if (flush_w) begin
            valid_w    <= 1'b0;
            regwrite_w <= 1'b0;
        end else if (!stall_w) begin
            valid_w    <= valid_m;
            regwrite_w <= regwrite_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_w        <= '0;
            resultsrc_q <= 2'b00;
            aluresult_q <= '0;
            readdata_q  <= '0;
            pcplus4_q   <= '0;
        end else if (!stall_w && !flush_w) begin
            rd_w        <= rd_m;
            resultsrc_q <= resultsrc_m;
            aluresult_q <= aluresult_m;
            readdata_q  <= readdata_m;
            pcplus4_q   <= pcplus4_m;
        end
    end

    // A retiring instruction still counts when it is flushed out behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 32'd0;
        end else if (valid_w && !stall_w) begin
            instret <= instret + 32'd1;
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [2:0]  funct3_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q <= 3'b000;
        end else if (!stall_w && !flush_w) begin
            funct3_q <= funct3_m;
        end
    end

    always_comb begin
        ld_byte = readdata_q[7:0];
        case (aluresult_q[1:0])
            2'd0:    ld_byte = readdata_q[7:0];
            2'd1:    ld_byte = readdata_q[15:8];
            2'd2:    ld_byte = readdata_q[23:16];
            default: ld_byte = readdata_q[31:24];
        endcase
        ld_half = aluresult_q[1] ? readdata_q[31:16] : readdata_q[15:0];
        case (funct3_q)
            3'b000:  load_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, ld_half};
            default: load_data = readdata_q;
        endcase
    end
`else
    logic unused_funct3;
    assign unused_funct3 = ^funct3_m;
    assign load_data     = readdata_q;
`endif

    always_comb begin
        case (resultsrc_q)
            2'b00:   wd3 = aluresult_q;
            2'b01:   wd3 = load_data;
            2'b10:   wd3 = pcplus4_q;
            default: wd3 = '0;
        endcase
    end

    // Writing x0 is suppressed; a held write during stall is harmless to repeat.
    assign we3 = valid_w && regwrite_w && (rd_w != '0);
    assign wa3 = rd_w;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the datapath width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register address width.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 Ports valid_m input 1 and regwrite_m input 1 SHALL carry, respectively, the memory-stage instruction-valid flag and the register-write enable.
REQ-006 Ports rd_m input ADDR_W (destination register) and resultsrc_m input 2 (00 ALU, 01 memory, 10 PC+4, 11 reserved) SHALL be provided.
REQ-007 Ports aluresult_m, readdata_m and pcplus4_m, each input DATA_W, SHALL carry the candidate results; funct3_m input 3 SHALL carry the load type.
REQ-008 Ports stall_w input 1 (hold) and flush_w input 1 (bubble) SHALL come from the hazard unit.
REQ-009 Ports we3 output 1, wa3 output ADDR_W and wd3 output DATA_W SHALL drive the register-file write port.
REQ-010 Ports valid_w output 1, regwrite_w output 1 and rd_w output ADDR_W SHALL expose writeback state for forwarding/hazard logic.
REQ-011 Port instret output 32 SHALL be the retired-instruction counter.

Function
REQ-012 A single pipeline register SHALL capture all *_m inputs on each rising edge where stall_w=0 and flush_w=0.
REQ-013 When flush_w=1 the block SHALL clear valid_w and regwrite_w on the next edge, regardless of stall_w (flush has priority over stall); data fields are don't-care.
REQ-014 When stall_w=1 and flush_w=0, all registered fields SHALL hold their values.
REQ-015 we3 SHALL equal valid_w AND regwrite_w AND (rd_w != 0), combinationally; we3 stays asserted while stalled (repeat write is idempotent).
REQ-016 wa3 SHALL equal rd_w; rd_w and regwrite_w SHALL be the registered values with no extra latency.
REQ-017 wd3 SHALL be selected combinationally from registered fields: 00 ALU result, 01 load data (REQ-026/027), 10 PC+4, 11 all zeros.
REQ-018 Latency SHALL be one cycle, memory-stage input to we3/wd3.
REQ-019 instret SHALL increment by 1 on each rising edge where valid_w=1 and stall_w=0, independent of regwrite_w.
REQ-020 instret SHALL wrap from 0xFFFFFFFF to 0x00000000 without a flag.
REQ-021 Simultaneous flush_w=1 with a retiring valid_w=1 SHALL still count the retiring instruction.
REQ-022 Destination x0 SHALL never assert we3, but SHALL still count as retired.

Reset
REQ-023 When rst_n=0 the block SHALL asynchronously clear valid_w, regwrite_w, rd_w, all data fields and instret to 0, forcing we3=0, wa3=0 and wd3=0.
REQ-024 Reset asserted mid-stall SHALL discard the held instruction; no write is issued after release.
REQ-025 After rst_n deasserts, the first capture SHALL occur on the first rising edge with stall_w=0.

Configuration
REQ-026 With macro WB_LOAD_EXT_EN defined, load data SHALL be extracted by aluresult[1:0] and funct3: 000 LB sign-extend byte, 001 LH sign-extend halfword (aluresult[1] selects), 100 LBU and 101 LHU zero-extend, 010 and all others pass the full word.
REQ-027 Without WB_LOAD_EXT_EN, load data SHALL be readdata passed unmodified and funct3 SHALL be ignored.

Verification
REQ-028 Bench: valid_m=1, regwrite_m=1, rd_m=5, resultsrc_m=00, aluresult_m=0x1234 -> next cycle we3=1, wa3=5, wd3=0x1234, instret=0 then 1 at the following edge.
REQ-029 Bench: rd_m=0 with regwrite_m=1 -> we3=0, and instret still increments by 1.
REQ-030 Bench: stall_w=1 for 3 cycles with a valid instruction held -> wd3/wa3 constant and instret unchanged; it increments once after release.
REQ-031 Bench: flush_w=1 together with stall_w=1 -> valid_w=0 and we3=0 on the next edge.
REQ-032 Bench: WB_LOAD_EXT_EN defined, readdata=0x80FF7F01, aluresult[1:0]=3, funct3=000 -> wd3=0xFFFFFF80; funct3=100 -> 0x00000080; macro undefined -> 0x80FF7F01.
REQ-033 Bench: preload instret=0xFFFFFFFF and retire one instruction -> instret=0; assert rst_n=0 mid-stall -> all outputs 0 immediately, with no clock edge required.
